// File: rtl/rvvi_retire_sequencer_if.sv
// Bundle of the per-slot retirement inputs and the serialized record stream.
// The sequencer takes the slave modport; the trace source/consumer side takes master.
interface rvvi_retire_sequencer_if #(
    parameter int unsigned ILEN   = 32,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NHART  = 1,
    parameter int unsigned RETIRE = 1,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned NSLOT = NHART * RETIRE;
    localparam int unsigned HW    = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int unsigned RW    = (RETIRE > 1) ? $clog2(RETIRE) : 1;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic [NSLOT-1:0]      in_valid;
    logic [NSLOT*ILEN-1:0] in_insn;
    logic [NSLOT*XLEN-1:0] in_pc;
    logic [NSLOT-1:0]      in_trap;

    logic                  out_valid;
    logic                  out_ready;
    logic [ILEN-1:0]       out_insn;
    logic                  out_compressed;
    logic [XLEN-1:0]       out_pc;
    logic                  out_trap;
    logic [HW-1:0]         out_hart;
    logic [RW-1:0]         out_ret;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [15:0]           drop_count;

    modport master (
        output in_valid, in_insn, in_pc, in_trap, out_ready,
        input  out_valid, out_insn, out_compressed, out_pc, out_trap, out_hart, out_ret,
        input  count, overflow, drop_count
    );

    modport slave (
        input  in_valid, in_insn, in_pc, in_trap, out_ready,
        output out_valid, out_insn, out_compressed, out_pc, out_trap, out_hart, out_ret,
        output count, overflow, drop_count
    );
endinterface

// File: rtl/rvvi_retire_sequencer.sv
// Compacts the valid retirement slots of all harts/ports into a FIFO and emits
// one record per cycle in retirement order, dropping (and counting) what does not fit.
module rvvi_retire_sequencer #(
    parameter int unsigned ILEN   = 32,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NHART  = 1,
    parameter int unsigned RETIRE = 1,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    rvvi_retire_sequencer_if.slave  bus
);
    localparam int unsigned NSLOT = NHART * RETIRE;
    localparam int unsigned HW    = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int unsigned RW    = (RETIRE > 1) ? $clog2(RETIRE) : 1;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [ILEN-1:0] mem_insn_q [DEPTH];
    logic [XLEN-1:0] mem_pc_q   [DEPTH];
    logic            mem_trap_q [DEPTH];
    logic            mem_comp_q [DEPTH];
    logic [HW-1:0]   mem_hart_q [DEPTH];
    logic [RW-1:0]   mem_ret_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;

    logic            slot_wen  [NSLOT];
    logic [PW-1:0]   slot_idx  [NSLOT];
    logic [ILEN-1:0] slot_insn [NSLOT];
    logic            slot_comp [NSLOT];
    logic [HW-1:0]   slot_hart [NSLOT];
    logic [RW-1:0]   slot_ret  [NSLOT];

    logic [CW-1:0] free_space, rank, accepted, dropped;
    logic [16:0]   drop_sum;
    logic          pop;

    assign pop        = (count_q != '0) && bus.out_ready;
    assign free_space = CW'(DEPTH) - count_q;

    // Rank each valid slot among the valid ones; only the first free_space get an entry.
    always_comb begin
        rank     = '0;
        accepted = '0;
        dropped  = '0;
        for (int s = 0; s < NSLOT; s++) begin
            slot_wen[s]  = 1'b0;
            slot_idx[s]  = wr_ptr_q + rank[PW-1:0];
            slot_comp[s] = bus.in_insn[s*ILEN +: 2] != 2'b11;
            slot_insn[s] = bus.in_insn[s*ILEN +: ILEN];
            if (slot_comp[s]) begin
                slot_insn[s] = {{(ILEN-16){1'b0}}, bus.in_insn[s*ILEN +: 16]};
            end
            slot_hart[s] = HW'(s / RETIRE);
            slot_ret[s]  = RW'(s % RETIRE);
            if (bus.in_valid[s]) begin
                if (rank < free_space) begin
                    slot_wen[s] = 1'b1;
                    accepted    = accepted + CW'(1);
                end else begin
                    dropped = dropped + CW'(1);
                end
                rank = rank + CW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + accepted[PW-1:0];
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + accepted - CW'(pop);
        overflow_d   = overflow_q || (dropped != '0);
        drop_sum     = 17'(drop_count_q) + 17'(dropped);
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_insn_q[i] <= '0;
                mem_pc_q[i]   <= '0;
                mem_trap_q[i] <= 1'b0;
                mem_comp_q[i] <= 1'b0;
                mem_hart_q[i] <= '0;
                mem_ret_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            for (int s = 0; s < NSLOT; s++) begin
                if (slot_wen[s]) begin
                    mem_insn_q[slot_idx[s]] <= slot_insn[s];
                    mem_pc_q[slot_idx[s]]   <= bus.in_pc[s*XLEN +: XLEN];
                    mem_trap_q[slot_idx[s]] <= bus.in_trap[s];
                    mem_comp_q[slot_idx[s]] <= slot_comp[s];
                    mem_hart_q[slot_idx[s]] <= slot_hart[s];
                    mem_ret_q[slot_idx[s]]  <= slot_ret[s];
                end
            end
        end
    end

    assign bus.out_valid      = count_q != '0;
    assign bus.out_insn       = mem_insn_q[rd_ptr_q];
    assign bus.out_compressed = mem_comp_q[rd_ptr_q];
    assign bus.out_pc         = mem_pc_q[rd_ptr_q];
    assign bus.out_trap       = mem_trap_q[rd_ptr_q];
    assign bus.out_hart       = mem_hart_q[rd_ptr_q];
    assign bus.out_ret        = mem_ret_q[rd_ptr_q];
    assign bus.count          = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.drop_count     = drop_count_q;
endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Directed bench for rvvi_retire_sequencer (2 harts x 2 retire ports, depth 8) with a
// queue-based reference model of acceptance, ordering, drops and reset.
module tb_rvvi_retire_sequencer;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned NHART  = 2;
    localparam int unsigned RETIRE = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NSLOT  = NHART * RETIRE;

    typedef struct {
        logic [ILEN-1:0] insn;
        logic            comp;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic            hart;
        logic            ret;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    rec_t q[$];
    logic m_over;
    int   m_drop;

    rvvi_retire_sequencer_if #(
        .ILEN(ILEN), .XLEN(XLEN), .NHART(NHART), .RETIRE(RETIRE), .DEPTH(DEPTH)
    ) bus ();

    rvvi_retire_sequencer #(
        .ILEN(ILEN), .XLEN(XLEN), .NHART(NHART), .RETIRE(RETIRE), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("overflow", 64'(bus.overflow), 64'(m_over));
        chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
        if (q.size() != 0) begin
            chk("out_insn", 64'(bus.out_insn), 64'(q[0].insn));
            chk("out_compressed", 64'(bus.out_compressed), 64'(q[0].comp));
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_trap", 64'(bus.out_trap), 64'(q[0].trap));
            chk("out_hart", 64'(bus.out_hart), 64'(q[0].hart));
            chk("out_ret", 64'(bus.out_ret), 64'(q[0].ret));
        end
    endtask

    // Check current outputs, advance the model for the upcoming edge, then take the edge.
    task automatic cycle();
        int   free_sp;
        int   taken;
        rec_t r;
        logic [ILEN-1:0] raw;
        check_state();
        if (reset) begin
            q.delete();
            m_over = 1'b0;
            m_drop = 0;
        end else begin
            free_sp = DEPTH - q.size();
            taken   = 0;
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            for (int s = 0; s < NSLOT; s++) begin
                if (bus.in_valid[s]) begin
                    if (taken < free_sp) begin
                        raw    = bus.in_insn[s*ILEN +: ILEN];
                        r.comp = raw[1:0] != 2'b11;
                        r.insn = r.comp ? {16'h0000, raw[15:0]} : raw;
                        r.pc   = bus.in_pc[s*XLEN +: XLEN];
                        r.trap = bus.in_trap[s];
                        r.hart = 1'(s / RETIRE);
                        r.ret  = 1'(s % RETIRE);
                        q.push_back(r);
                        taken++;
                    end else begin
                        m_over = 1'b1;
                        m_drop = (m_drop >= 65535) ? 65535 : m_drop + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [ILEN-1:0] insn,
                            input logic [XLEN-1:0] pc, input logic trap);
        bus.in_valid[s]              = 1'b1;
        bus.in_insn[s*ILEN +: ILEN]  = insn;
        bus.in_pc[s*XLEN +: XLEN]    = pc;
        bus.in_trap[s]               = trap;
    endtask

    task automatic clear_slots();
        bus.in_valid = '0;
        bus.in_insn  = '0;
        bus.in_pc    = '0;
        bus.in_trap  = '0;
    endtask

    task automatic fill_all(input int base);
        for (int s = 0; s < NSLOT; s++) begin
            set_slot(s, 32'h0000_0013 | (32'(base + s) << 20), 64'h1000 + 64'(4 * (base + s)),
                     1'((base + s) % 3 == 0));
        end
    endtask

    initial begin
        m_over = 1'b0;
        m_drop = 0;
        reset  = 1'b1;
        bus.out_ready = 1'b1;
        clear_slots();
        @(posedge clk);
        #1;
        cycle();                       // reset-state checks, still in reset
        reset = 1'b0;

        // Pass-through, single slot
        set_slot(0, 32'h00A0_0093, 64'h8000_0000, 1'b0);
        cycle();
        clear_slots();
        cycle();
        cycle();

        // Compressed trimming
        set_slot(0, 32'hDEAD_4501, 64'h8000_0004, 1'b0);
        cycle();
        clear_slots();
        cycle();
        cycle();

        // Ordering across all four slots in one cycle
        fill_all(1);
        cycle();
        clear_slots();
        repeat (5) cycle();

        // Overflow: four full cycles with the consumer stalled
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            fill_all(10 + 4 * c);
            cycle();
        end
        clear_slots();
        cycle();
        cycle();                       // head held while stalled

        // Push + pop at full: pop happens, both pushes dropped
        bus.out_ready = 1'b1;
        set_slot(0, 32'h0000_1111, 64'h2000, 1'b0);
        set_slot(3, 32'h0000_2223, 64'h2004, 1'b1);
        cycle();
        clear_slots();
        bus.out_ready = 1'b0;
        cycle();

        // Drain two to reach count=5, then reset with slots valid
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.out_ready = 1'b0;
        fill_all(40);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_slots();
        set_slot(1, 32'h0041_8193, 64'h3000, 1'b1);
        cycle();                       // post-reset checks, first enqueue
        clear_slots();
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        // Wraparound drain with mixed pushes and pops
        for (int c = 0; c < 6; c++) begin
            set_slot(c % NSLOT, 32'h0000_0013 | (32'(60 + c) << 20), 64'h4000 + 64'(c), 1'b0);
            set_slot((c + 2) % NSLOT, 32'h0000_8001 | 32'(c << 4), 64'h5000 + 64'(c), 1'b1);
            cycle();
            clear_slots();
        end
        repeat (10) cycle();

        // drop_count saturation
        bus.out_ready = 1'b0;
        fill_all(80);
        for (int c = 0; c < 16400; c++) cycle();
        clear_slots();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
